// File: rtl/mc_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// mc_fsm_ctrl -- control FSM for a multi-cycle MIPS-like datapath.
//
// Sequences each instruction through FETCH / DECODE / execute / writeback
// states and decodes datapath strobes and mux selects. FETCH, MEMRD and MEMWR
// are stretched by MEM_WAIT extra cycles with a small wait counter.
//
// Parameters:
//   MEM_WAIT  extra wait cycles per memory access (0..15)
//   ALUCTL_W  width of alu_ctl (>= 3), ALU codes zero-extended
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   opcode      IR[15:10], stable from DECODE onward
//   funct       R-type function field
//   zero        ALU zero flag (drives pc_en in BEQ combinationally)
//   pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
//   alu_src_a   datapath strobes / 1-bit mux selects
//   alu_src_b   00 regB, 01 const 1, 10 sign-extended immediate
//   pc_src      00 ALU result, 01 ALUOut, 10 jump target
//   alu_ctl     and 000, or 001, add 010, sub 110, slt 111
//   state       current state code (debug)
//   illegal     one-cycle pulse on unsupported opcode or funct
// -----------------------------------------------------------------------------
module mc_fsm_ctrl #(
   parameter int MEM_WAIT = 0,
   parameter int ALUCTL_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          pc_src,
   output logic [ALUCTL_W-1:0] alu_ctl,
   output logic [3:0]          state,
   output logic                illegal
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQ    = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(3'b000);
   localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3'b001);
   localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b010);
   localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b110);
   localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(3'b111);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_t     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       wait_last;

   // With MEM_WAIT=0 the compare is always true, so memory states take a
   // single cycle and the counter never advances.
   assign wait_last = (wait_q == WAIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next-state logic. The wait counter defaults to 0 so it is cleared on
   // every state exit and in every single-cycle state.
   always_comb begin
      state_d = state_q;
      wait_d  = 4'd0;
      case (state_q)
         S_FETCH: begin
            if (wait_last) state_d = S_DECODE;
            else           wait_d  = wait_q + 4'd1;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_RTEX;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (wait_last) state_d = S_MEMWB;
            else           wait_d  = wait_q + 4'd1;
         end
         S_MEMWR: begin
            if (wait_last) state_d = S_FETCH;
            else           wait_d  = wait_q + 4'd1;
         end
         S_RTEX:   state_d = S_RTWB;
         S_ADDIEX: state_d = S_ADDIWB;
         // MEMWB, RTWB, BEQ, ADDIWB, JUMP and unused codes all return to FETCH.
         default:  state_d = S_FETCH;
      endcase
   end

   assign state = state_q;

   // Output decode. Everything is forced low while rst is high, since the
   // reset state FETCH would otherwise drive nonzero selects.
   always_comb begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_ctl    = '0;
      illegal    = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               alu_src_b = 2'b01;
               alu_ctl   = ALU_ADD;
               ir_write  = wait_last;
               pc_en     = wait_last;
            end
            S_DECODE: begin
               alu_src_b = 2'b10;
               alu_ctl   = ALU_ADD;
               case (opcode)
                  OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                  default:                                   illegal = 1'b1;
               endcase
            end
            S_MEMADR, S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctl   = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWR: begin
               iord      = 1'b1;
               mem_write = wait_last;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_RTEX: begin
               alu_src_a = 1'b1;
               case (funct)
                  6'b100000: alu_ctl = ALU_ADD;
                  6'b100010: alu_ctl = ALU_SUB;
                  6'b100100: alu_ctl = ALU_AND;
                  6'b100101: alu_ctl = ALU_OR;
                  6'b101010: alu_ctl = ALU_SLT;
                  default: begin
                     // Unknown funct: flag it but still let RTWB happen.
                     alu_ctl = ALU_ADD;
                     illegal = 1'b1;
                  end
               endcase
            end
            S_RTWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BEQ: begin
               alu_src_a = 1'b1;
               alu_ctl   = ALU_SUB;
               pc_src    = 2'b01;
               pc_en     = zero;
            end
            S_JUMP: begin
               pc_src = 2'b10;
               pc_en  = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_fsm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_fsm_ctrl -- self-checking bench for mc_fsm_ctrl.
//
// Three instances with MEM_WAIT = 0, 2 and 3 share clock and instruction
// inputs; the ones not under test are held in reset. Checks: a table of
// per-instruction totals, hand-written multi-cycle sequences (sw with waits,
// async reset in MEMRD, reset abort in MEMWR) and random instruction streams
// compared cycle by cycle against an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_mc_fsm_ctrl;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_ctl;
      logic [3:0] state;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         cyc;
      int         pc;
      int         ir;
      int         mw;
      int         rw;
      int         ill;
   } vec_t;

   logic       clk;
   logic       rst_v [3];
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   outs_t      o [3];
   outs_t      cur;
   logic [1:0] sel;

   int errors = 0;
   int checks = 0;
   outs_t exp_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b, pc_src;
      logic [2:0] alu_ctl;
      logic [3:0] state;
      logic       illegal;
      mc_fsm_ctrl #(
         .MEM_WAIT (gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
         .ALUCTL_W (3)
      ) u_dut (
         .clk        (clk),
         .rst        (rst_v[gi]),
         .opcode     (opcode),
         .funct      (funct),
         .zero       (zero),
         .pc_en      (pc_en),
         .iord       (iord),
         .mem_write  (mem_write),
         .ir_write   (ir_write),
         .reg_dst    (reg_dst),
         .mem_to_reg (mem_to_reg),
         .reg_write  (reg_write),
         .alu_src_a  (alu_src_a),
         .alu_src_b  (alu_src_b),
         .pc_src     (pc_src),
         .alu_ctl    (alu_ctl),
         .state      (state),
         .illegal    (illegal)
      );
      assign o[gi] = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                      alu_src_a, alu_src_b, pc_src, alu_ctl, state, illegal};
   end

   assign cur = o[sel];

   function automatic int mw_of(input logic [1:0] s);
      return (s == 2'd0) ? 0 : ((s == 2'd1) ? 2 : 3);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input outs_t act, input outs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h (state got %0d exp %0d)",
                  name, act, exp, act.state, exp.state);
      end
   endtask

   // Reference model: expands one instruction into its expected per-cycle
   // output vectors, working from the instruction class and memory latency.
   task automatic model_instr(input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input int mw);
      outs_t c;
      for (int i = 0; i <= mw; i++) begin
         c = '0; c.state = 4'd0; c.alu_src_b = 2'b01; c.alu_ctl = 3'b010;
         c.ir_write = (i == mw); c.pc_en = (i == mw);
         exp_q.push_back(c);
      end
      c = '0; c.state = 4'd1; c.alu_src_b = 2'b10; c.alu_ctl = 3'b010;
      c.illegal = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
      exp_q.push_back(c);
      if (op == 6'b100011 || op == 6'b101011) begin
         c = '0; c.state = 4'd2; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = 3'b010;
         exp_q.push_back(c);
         for (int i = 0; i <= mw; i++) begin
            c = '0; c.iord = 1'b1;
            c.state = (op == 6'b100011) ? 4'd3 : 4'd5;
            c.mem_write = (op == 6'b101011) && (i == mw);
            exp_q.push_back(c);
         end
         if (op == 6'b100011) begin
            c = '0; c.state = 4'd4; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
            exp_q.push_back(c);
         end
      end else if (op == 6'b000000) begin
         c = '0; c.state = 4'd6; c.alu_src_a = 1'b1;
         case (fn)
            6'b100000: c.alu_ctl = 3'b010;
            6'b100010: c.alu_ctl = 3'b110;
            6'b100100: c.alu_ctl = 3'b000;
            6'b100101: c.alu_ctl = 3'b001;
            6'b101010: c.alu_ctl = 3'b111;
            default: begin c.alu_ctl = 3'b010; c.illegal = 1'b1; end
         endcase
         exp_q.push_back(c);
         c = '0; c.state = 4'd7; c.reg_write = 1'b1; c.reg_dst = 1'b1;
         exp_q.push_back(c);
      end else if (op == 6'b000100) begin
         c = '0; c.state = 4'd8; c.alu_src_a = 1'b1; c.alu_ctl = 3'b110;
         c.pc_src = 2'b01; c.pc_en = z;
         exp_q.push_back(c);
      end else if (op == 6'b001000) begin
         c = '0; c.state = 4'd9; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_ctl = 3'b010;
         exp_q.push_back(c);
         c = '0; c.state = 4'd10; c.reg_write = 1'b1;
         exp_q.push_back(c);
      end else if (op == 6'b000010) begin
         c = '0; c.state = 4'd11; c.pc_src = 2'b10; c.pc_en = 1'b1;
         exp_q.push_back(c);
      end
   endtask

   // Hold every instance in reset, check the selected one is all-zero, then
   // release it just after a rising edge: that cycle is FETCH cycle 0.
   task automatic do_reset(input logic [1:0] k);
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;
      sel = k;
      @(posedge clk); #1;
      chk_vec($sformatf("reset_outs_dut%0d", k), cur, '0);
      @(posedge clk); #1;
      rst_v[k] = 1'b0;
   endtask

   // Run one instruction from FETCH cycle 0, comparing every cycle.
   task automatic run_model(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input string tag);
      int n;
      opcode = op; funct = fn; zero = z;
      exp_q.delete();
      model_instr(op, fn, z, mw_of(sel));
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         #1;
         chk_vec($sformatf("%s_op%b_fn%b_z%0d_cyc%0d", tag, op, fn, z, i), cur, exp_q[i]);
         @(posedge clk); #1;
      end
      $display("instr %s dut%0d op=%b fn=%b z=%0d cycles=%0d", tag, sel, op, fn, z, n);
   endtask

   // Run one instruction and total its strobes until FETCH returns.
   task automatic run_count(input vec_t v, input int idx);
      int cyc, pc, ir, mw, rw, ill;
      cyc = 0; pc = 0; ir = 0; mw = 0; rw = 0; ill = 0;
      opcode = v.op; funct = v.fn; zero = v.z;
      do begin
         #1;
         pc += int'(cur.pc_en); ir += int'(cur.ir_write); mw += int'(cur.mem_write);
         rw += int'(cur.reg_write); ill += int'(cur.illegal);
         cyc++;
         @(posedge clk); #1;
      end while (cur.state != 4'd0 && cyc < 40);
      chk($sformatf("tab%0d_cycles", idx), cyc, v.cyc);
      chk($sformatf("tab%0d_pc_en", idx), pc, v.pc);
      chk($sformatf("tab%0d_ir_write", idx), ir, v.ir);
      chk($sformatf("tab%0d_mem_write", idx), mw, v.mw);
      chk($sformatf("tab%0d_reg_write", idx), rw, v.rw);
      chk($sformatf("tab%0d_illegal", idx), ill, v.ill);
      $display("table %0d op=%b fn=%b z=%0d cycles=%0d pc=%0d ir=%0d mw=%0d rw=%0d ill=%0d",
               idx, v.op, v.fn, v.z, cyc, pc, ir, mw, rw, ill);
   endtask

   task automatic wait_state(input logic [3:0] s, input string tag);
      int n;
      n = 0;
      while (cur.state != s && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      chk($sformatf("%s_reach_state%0d", tag, s), int'(cur.state), int'(s));
   endtask

   initial begin : main
      vec_t       tab [11];
      logic [7:0] ir_t, mw_t, io_t;
      logic [31:0] st_t;
      logic [5:0] ops [6];
      logic [5:0] fns [5];
      logic [5:0] op, fn;

      tab[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 1, 0, 1, 0}; // lw
      tab[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 1, 1, 1, 0, 0}; // sw
      tab[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 1, 0, 1, 0}; // add
      tab[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 1, 1, 0, 1, 0}; // sub
      tab[4]  = '{6'b000000, 6'b000000, 1'b0, 4, 1, 1, 0, 1, 1}; // bad funct
      tab[5]  = '{6'b000100, 6'b000000, 1'b1, 3, 2, 1, 0, 0, 0}; // beq taken
      tab[6]  = '{6'b000100, 6'b000000, 1'b0, 3, 1, 1, 0, 0, 0}; // beq not taken
      tab[7]  = '{6'b001000, 6'b000000, 1'b0, 4, 1, 1, 0, 1, 0}; // addi
      tab[8]  = '{6'b000010, 6'b000000, 1'b0, 3, 2, 1, 0, 0, 0}; // j
      tab[9]  = '{6'b111111, 6'b000000, 1'b0, 2, 1, 1, 0, 0, 1}; // bad opcode
      tab[10] = '{6'b000000, 6'b101010, 1'b1, 4, 1, 1, 0, 1, 0}; // slt

      ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

      opcode = '0; funct = '0; zero = 1'b0; sel = 2'd0;
      for (int i = 0; i < 3; i++) rst_v[i] = 1'b1;

      // Table of per-instruction totals, MEM_WAIT=0.
      do_reset(2'd0);
      for (int i = 0; i < 11; i++) run_count(tab[i], i);

      // Directed per-cycle checks of the key instruction shapes.
      do_reset(2'd0);
      run_model(6'b100011, 6'b000000, 1'b0, "lw_mw0");
      run_model(6'b000000, 6'b100010, 1'b0, "rsub_mw0");
      run_model(6'b000000, 6'b000000, 1'b0, "rbad_mw0");
      run_model(6'b000100, 6'b000000, 1'b1, "beq1_mw0");
      run_model(6'b000100, 6'b000000, 1'b0, "beq0_mw0");
      run_model(6'b111111, 6'b000000, 1'b0, "ill_mw0");

      // sw with MEM_WAIT=2: trace eight cycles against hand-written patterns.
      do_reset(2'd1);
      opcode = 6'b101011; funct = '0; zero = 1'b0;
      ir_t = '0; mw_t = '0; io_t = '0; st_t = '0;
      for (int i = 0; i < 8; i++) begin
         #1;
         ir_t[i] = cur.ir_write; mw_t[i] = cur.mem_write; io_t[i] = cur.iord;
         st_t[4*i +: 4] = cur.state;
         @(posedge clk); #1;
      end
      chk("sw_mw2_states", int'(st_t), int'(32'h5552_1000));
      chk("sw_mw2_ir_write", int'(ir_t), int'(8'b0000_0100));
      chk("sw_mw2_mem_write", int'(mw_t), int'(8'b1000_0000));
      chk("sw_mw2_iord", int'(io_t), int'(8'b1110_0000));
      chk("sw_mw2_back_to_fetch", int'(cur.state), 0);
      $display("seq sw_mw2 states=%08h ir=%b mw=%b iord=%b", st_t, ir_t, mw_t, io_t);

      // Reset aborting MEMWR: no mem_write may follow.
      run_model(6'b101011, 6'b000000, 1'b0, "sw_mw2");
      opcode = 6'b101011;
      wait_state(4'd5, "abort_memwr");
      #3 rst_v[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_vec($sformatf("abort_memwr_outs%0d", i), cur, '0);
         @(posedge clk); #1;
      end
      rst_v[1] = 1'b0;
      run_model(6'b001000, 6'b000000, 1'b0, "after_abort");
      $display("seq abort_memwr done");

      // Asynchronous reset in MEMRD with MEM_WAIT=3.
      do_reset(2'd2);
      opcode = 6'b100011; funct = '0; zero = 1'b0;
      wait_state(4'd3, "async_memrd");
      @(posedge clk); #3;
      rst_v[2] = 1'b1;
      #1;
      chk_vec("async_rst_outs_before_edge", cur, '0);
      @(posedge clk); #1;
      chk_vec("async_rst_outs_held", cur, '0);
      rst_v[2] = 1'b0;
      run_model(6'b100011, 6'b000000, 1'b0, "after_async");
      $display("seq async_rst_memrd done");

      // Random instruction streams on each latency.
      for (int k = 0; k < 3; k++) begin
         do_reset(2'(k));
         for (int n = 0; n < 14; n++) begin
            op = ($urandom_range(0, 7) < 6) ? ops[$urandom_range(0, 5)] : 6'($urandom);
            fn = ($urandom_range(0, 3) < 3) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            run_model(op, fn, 1'($urandom), "rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
